// File: rtl/muldiv_unit.sv
// Iterative radix-2 multiply/divide unit for the RV32IM M-extension.
// One shift-add or restoring-divide step per cycle, start/done handshake.
`timescale 1ns/1ps

package muldiv_pkg;
  typedef enum logic [4:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_SRA,
    ALU_OR, ALU_AND,
    ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU, ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU
  } alu_op_e;
endpackage

module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  alu_op_e         alu_op,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic            kill,
  output logic            ready,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_e;

  state_e          state, state_nxt;
  logic [4:0]      cnt;
  alu_op_e         op_q;
  logic            sign_a_q, sign_b_q;
  logic [XLEN-1:0] opnd_q;
  logic [XLEN-1:0] hi_q, lo_q;

  function automatic logic [XLEN-1:0] neg_w(input logic [XLEN-1:0] v);
    return ~v + XLEN'(1);
  endfunction

  function automatic logic [2*XLEN-1:0] neg_d(input logic [2*XLEN-1:0] v);
    return ~v + (2*XLEN)'(1);
  endfunction

  // Request decode, evaluated combinationally while IDLE
  logic            is_m, is_div, sgn_a, sgn_b, neg_a, neg_b, div_zero, div_ovf, fast;
  logic [XLEN-1:0] mag_a, mag_b, fast_val;

  always_comb begin
    is_m     = alu_op inside {ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU,
                              ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU};
    is_div   = alu_op inside {ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU};
    sgn_a    = alu_op inside {ALU_MULH, ALU_MULHSU, ALU_DIV, ALU_REM};
    sgn_b    = alu_op inside {ALU_MULH, ALU_DIV, ALU_REM};
    neg_a    = sgn_a & op_a[XLEN-1];
    neg_b    = sgn_b & op_b[XLEN-1];
    mag_a    = neg_a ? neg_w(op_a) : op_a;
    mag_b    = neg_b ? neg_w(op_b) : op_b;
    div_zero = (op_b == '0);
    div_ovf  = (alu_op inside {ALU_DIV, ALU_REM}) && (op_a == {1'b1, {(XLEN-1){1'b0}}})
               && (op_b == '1);
    fast     = is_div && (div_zero || div_ovf);
    fast_val = '0;
    if (div_zero)
      fast_val = (alu_op inside {ALU_DIV, ALU_DIVU}) ? '1 : op_a;
    else if (div_ovf)
      fast_val = (alu_op == ALU_DIV) ? {1'b1, {(XLEN-1){1'b0}}} : '0;
  end

  // One iteration step for each algorithm
  logic [XLEN:0]   mul_sum, div_diff;
  logic [XLEN-1:0] div_shift;
  logic            div_nb;

  always_comb begin
    mul_sum   = lo_q[0] ? ({1'b0, hi_q} + {1'b0, opnd_q}) : {1'b0, hi_q};
    div_shift = {hi_q[XLEN-2:0], lo_q[XLEN-1]};
    div_diff  = {1'b0, div_shift} - {1'b0, opnd_q};
    div_nb    = hi_q[XLEN-1] | ~div_diff[XLEN];
  end

  // Sign correction and word select for the final result
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   fix_val;

  always_comb begin
    prod    = (sign_a_q ^ sign_b_q) ? neg_d({hi_q, lo_q}) : {hi_q, lo_q};
    fix_val = '0;
    case (op_q)
      ALU_MUL:                         fix_val = prod[XLEN-1:0];
      ALU_MULH, ALU_MULHSU, ALU_MULHU: fix_val = prod[2*XLEN-1:XLEN];
      ALU_DIV, ALU_DIVU:               fix_val = (sign_a_q ^ sign_b_q) ? neg_w(lo_q) : lo_q;
      ALU_REM, ALU_REMU:               fix_val = sign_a_q ? neg_w(hi_q) : hi_q;
      default:                         fix_val = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (kill) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE: if (start && is_m) state_nxt = fast ? S_DONE : S_CALC;
        S_CALC: if (cnt == 5'd31) state_nxt = S_FIX;
        S_FIX:  state_nxt = S_DONE;
        S_DONE: state_nxt = S_IDLE;
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  always_comb begin
    ready = (state == S_IDLE);
    busy  = (state != S_IDLE);
    done  = (state == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= '0;
      result <= '0;
    end else if (!kill) begin
      if (state == S_CALC) cnt <= cnt + 5'd1;
      else                 cnt <= '0;
      if (state == S_IDLE && start && is_m && fast) result <= fast_val;
      else if (state == S_FIX)                      result <= fix_val;
    end else begin
      cnt <= '0;
    end
  end

  // Operand/accumulator registers carry no reset; they are always loaded on accept
  always_ff @(posedge clk) begin
    if (state == S_IDLE && start && is_m && !kill) begin
      op_q     <= alu_op;
      sign_a_q <= neg_a;
      sign_b_q <= neg_b;
      hi_q     <= '0;
      opnd_q   <= is_div ? mag_b : mag_a;
      lo_q     <= is_div ? mag_a : mag_b;
    end else if (state == S_CALC) begin
      if (op_q inside {ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU}) begin
        hi_q <= div_nb ? div_diff[XLEN-1:0] : div_shift;
        lo_q <= {lo_q[XLEN-2:0], div_nb};
      end else begin
        hi_q <= mul_sum[XLEN:1];
        lo_q <= {mul_sum[0], lo_q[XLEN-1:1]};
      end
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Randomized and directed bench for muldiv_unit against an arithmetic reference model.
`timescale 1ns/1ps

module tb_muldiv_unit;
  import muldiv_pkg::*;

  logic        clk = 1'b0;
  logic        rst, start, kill;
  alu_op_e     alu_op;
  logic [31:0] op_a, op_b;
  logic        ready, busy, done;
  logic [31:0] result;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] exp_last;

  muldiv_unit #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .start(start), .alu_op(alu_op), .op_a(op_a), .op_b(op_b),
    .kill(kill), .ready(ready), .busy(busy), .done(done), .result(result)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] model(input alu_op_e op, input logic [31:0] a,
                                        input logic [31:0] b);
    longint sa, sb, ua, ub, q;
    logic [63:0] p;
    logic ovf;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ua  = longint'({32'h0, a});
    ub  = longint'({32'h0, b});
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (op)
      ALU_MUL:    begin p = ua * ub; return p[31:0];  end
      ALU_MULH:   begin p = sa * sb; return p[63:32]; end
      ALU_MULHSU: begin p = sa * ub; return p[63:32]; end
      ALU_MULHU:  begin p = ua * ub; return p[63:32]; end
      ALU_DIV:  begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (ovf) return 32'h8000_0000;
        q = sa / sb; return q[31:0];
      end
      ALU_REM:  begin
        if (b == 0) return a;
        if (ovf) return 32'h0;
        q = sa % sb; return q[31:0];
      end
      ALU_DIVU: begin if (b == 0) return 32'hFFFF_FFFF; q = ua / ub; return q[31:0]; end
      ALU_REMU: begin if (b == 0) return a; q = ua % ub; return q[31:0]; end
      default: return 32'h0;
    endcase
  endfunction

  function automatic int model_lat(input alu_op_e op, input logic [31:0] a, input logic [31:0] b);
    if (op inside {ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU} && b == 0) return 1;
    if (op inside {ALU_DIV, ALU_REM} && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 34;
  endfunction

  // Issue one request in IDLE and wait (bounded) for done; returns at posedge+1 in the DONE cycle.
  task automatic issue(input alu_op_e op, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] res, output int lat, output bit got);
    @(negedge clk);
    start = 1'b1; alu_op = op; op_a = a; op_b = b;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 1; got = 1'b0; res = 'x;
    while (lat < 100) begin
      if (done) begin got = 1'b1; res = result; break; end
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic to_idle();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; kill = 1'b0; alu_op = ALU_ADD; op_a = '0; op_b = '0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if ({ready, busy, done} !== 3'b100 || result !== 32'h0) begin
      n_err++;
      $display("FAIL reset: ready/busy/done=%b result=%h, want 100 / 00000000",
               {ready, busy, done}, result);
    end
    @(negedge clk); rst = 1'b0;
    exp_last = 32'h0;
  endtask

  task automatic test_directed();
    alu_op_e     ops [16] = '{ALU_MUL, ALU_MULH, ALU_MULHU, ALU_MULHSU, ALU_DIV, ALU_REM,
                              ALU_DIVU, ALU_REMU, ALU_DIV, ALU_REMU, ALU_DIV, ALU_REM,
                              ALU_DIVU, ALU_REM, ALU_MULHSU, ALU_MULH};
    logic [31:0] av [16] = '{32'd7, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                             32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100, 32'd100,
                             32'd55, 32'h1234, 32'h8000_0000, 32'h8000_0000,
                             32'hFFFF_FFFF, 32'd7, 32'h0000_0002, 32'hFFFF_FFFF};
    logic [31:0] bv [16] = '{32'hFFFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                             32'd2, 32'd2, 32'd7, 32'd7, 32'd0, 32'd0,
                             32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFE,
                             32'hFFFF_FFFF, 32'h0000_0001};
    logic [31:0] ev [16] = '{32'hFFFF_FFF9, 32'h4000_0000, 32'hFFFF_FFFE, 32'hFFFF_FFFF,
                             32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd14, 32'd2,
                             32'hFFFF_FFFF, 32'h1234, 32'h8000_0000, 32'h0,
                             32'd1, 32'd1, 32'h0000_0001, 32'hFFFF_FFFF};
    int          el [16] = '{34, 34, 34, 34, 34, 34, 34, 34, 1, 1, 1, 1, 34, 34, 34, 34};
    logic [31:0] res;
    int          lat;
    bit          got;
    for (int i = 0; i < 16; i++) begin
      issue(ops[i], av[i], bv[i], res, lat, got);
      n_cmp++;
      if (!got || res !== ev[i] || lat != el[i]) begin
        n_err++;
        $display("FAIL directed[%0d] %s: result=%h lat=%0d got=%0d, want %h lat=%0d",
                 i, ops[i].name(), res, lat, got, ev[i], el[i]);
      end
      exp_last = ev[i];
      to_idle();
    end
  endtask

  task automatic test_random();
    alu_op_e     mops [8] = '{ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU,
                              ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU};
    alu_op_e     op;
    logic [31:0] a, b, res, exp;
    int          lat, mode;
    bit          got;
    for (int i = 0; i < 60; i++) begin
      op   = mops[$urandom_range(0, 7)];
      mode = $urandom_range(0, 5);
      a = $urandom; b = $urandom;
      if (mode == 0) b = 32'h0;
      else if (mode == 1) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
      else if (mode == 2) begin a = $urandom_range(0, 300); b = $urandom_range(1, 20); end
      else if (mode == 3) b = -$urandom_range(1, 9);
      exp = model(op, a, b);
      issue(op, a, b, res, lat, got);
      n_cmp++;
      if (!got || res !== exp || lat != model_lat(op, a, b)) begin
        n_err++;
        $display("FAIL random[%0d] %s a=%h b=%h: result=%h lat=%0d, want %h lat=%0d",
                 i, op.name(), a, b, res, lat, exp, model_lat(op, a, b));
      end
      exp_last = exp;
      to_idle();
    end
  endtask

  task automatic test_non_m();
    bit bad = 1'b0;
    @(negedge clk);
    start = 1'b1; alu_op = ALU_ADD; op_a = 32'd1; op_b = 32'd2;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (busy || done || !ready || result !== exp_last) bad = 1'b1;
      @(posedge clk); #1;
    end
    n_cmp++;
    if (bad) begin
      n_err++;
      $display("FAIL non_m_ignored: busy=%b done=%b result=%h, want 0 0 %h",
               busy, done, result, exp_last);
    end
  endtask

  task automatic test_busy_ignore();
    int lat;
    bit got = 1'b0;
    @(negedge clk);
    start = 1'b1; alu_op = ALU_MULHU; op_a = 32'hFFFF_FFFF; op_b = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    start = 1'b0; lat = 1;
    repeat (5) begin @(posedge clk); #1; lat++; end
    @(negedge clk);
    start = 1'b1; alu_op = ALU_DIVU; op_a = 32'd9; op_b = 32'd0;
    @(posedge clk); #1;
    start = 1'b0; op_a = 32'd3; op_b = 32'd3; lat++;
    while (lat < 100) begin
      if (done) begin got = 1'b1; break; end
      @(posedge clk); #1;
      lat++;
    end
    n_cmp++;
    if (!got || result !== 32'hFFFF_FFFE || lat != 34) begin
      n_err++;
      $display("FAIL busy_ignore: result=%h lat=%0d got=%0d, want fffffffe lat=34",
               result, lat, got);
    end
    exp_last = 32'hFFFF_FFFE;
    to_idle();
  endtask

  task automatic test_kill();
    logic [31:0] res;
    int          lat;
    bit          got, saw_done = 1'b0;
    @(negedge clk);
    start = 1'b1; alu_op = ALU_MUL; op_a = 32'd1000; op_b = 32'd1000;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk); kill = 1'b1;
    @(posedge clk); #1; kill = 1'b0;
    n_cmp++;
    if (busy !== 1'b0 || ready !== 1'b1) begin
      n_err++;
      $display("FAIL kill_idle: busy=%b ready=%b, want 0 1", busy, ready);
    end
    repeat (40) begin if (done) saw_done = 1'b1; @(posedge clk); #1; end
    n_cmp++;
    if (saw_done || result !== exp_last) begin
      n_err++;
      $display("FAIL kill_no_done: saw_done=%b result=%h, want 0 %h", saw_done, result, exp_last);
    end
    issue(ALU_MUL, 32'd3, 32'd5, res, lat, got);
    n_cmp++;
    if (!got || res !== 32'd15 || lat != 34) begin
      n_err++;
      $display("FAIL kill_then_mul: result=%h lat=%0d, want 0000000f lat=34", res, lat);
    end
    exp_last = 32'd15;
    to_idle();
  endtask

  task automatic test_rst_mid();
    @(negedge clk);
    start = 1'b1; alu_op = ALU_DIVU; op_a = 32'd77; op_b = 32'd5;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (6) @(posedge clk);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    n_cmp++;
    if (busy !== 1'b0 || ready !== 1'b1 || result !== 32'h0 || done !== 1'b0) begin
      n_err++;
      $display("FAIL rst_mid: busy=%b ready=%b done=%b result=%h, want 0 1 0 00000000",
               busy, ready, done, result);
    end
    @(negedge clk); rst = 1'b0;
    exp_last = 32'h0;
  endtask

  task automatic test_back_to_back();
    logic [31:0] r1, r2;
    int          l1, l2;
    bit          g1, g2;
    issue(ALU_REM, 32'hFFFF_FF9C, 32'd7, r1, l1, g1);
    @(posedge clk); #1;
    n_cmp++;
    if (done !== 1'b0 || ready !== 1'b1) begin
      n_err++;
      $display("FAIL b2b_pulse: done=%b ready=%b after DONE, want 0 1", done, ready);
    end
    @(negedge clk);
    start = 1'b1; alu_op = ALU_MULH; op_a = 32'hFFFF_FFFD; op_b = 32'h4000_0000;
    @(posedge clk); #1;
    start = 1'b0; l2 = 1; g2 = 1'b0;
    while (l2 < 100) begin
      if (done) begin g2 = 1'b1; break; end
      @(posedge clk); #1;
      l2++;
    end
    r2 = result;
    n_cmp++;
    if (!g1 || r1 !== 32'hFFFF_FFFE || l1 != 34) begin
      n_err++;
      $display("FAIL b2b_first: result=%h lat=%0d, want fffffffe lat=34", r1, l1);
    end
    n_cmp++;
    if (!g2 || r2 !== 32'hFFFF_FFFF || l2 != 34) begin
      n_err++;
      $display("FAIL b2b_second: result=%h lat=%0d, want ffffffff lat=34", r2, l2);
    end
    to_idle();
  endtask

  initial begin
    test_reset();
    test_directed();
    test_non_m();
    test_busy_ignore();
    test_kill();
    test_rst_mid();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
